// File: rtl/hazard_controller.sv
// hazard_controller: pipeline hazard sequencer for the 5-stage core.
// Covers what operand forwarding cannot resolve:
//   - load-use stalls
//   - IF/ID and ID/EX flushes on a branch/jump redirect
//   - whole-pipe freezes while data memory is busy
// Control outputs are combinational from state and inputs, so the reaction
// is in the same cycle. They are forced low while reset_n is low.
// Optional feature macro: HAZARD_STATS_EN. It adds the saturating
// luStallCount, flushCount and memWaitCount event counters.
module hazard_controller #(
  parameter logic [3:0] OP_LW        = 4'b0100,
  parameter logic [3:0] OP_NOP       = 4'b0000,
  parameter int         LU_STALL     = 1,
  parameter int         FLUSH_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] opId,
  input  logic [3:0] reg1Id,
  input  logic [3:0] reg2Id,
  input  logic       reg1UsedId,
  input  logic       reg2UsedId,
  input  logic [3:0] opEx,
  input  logic [3:0] regDestEx,
  input  logic       wrEnEx,
  input  logic       redirectEx,
  input  logic       memBusy,
  output logic       stallPc,
  output logic       stallIfId,
  output logic       bubbleEx,
  output logic       flushIfId,
  output logic       flushIdEx,
  output logic       stallAll,
  output logic [1:0] hzState
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] luStallCount,
  output logic [15:0] flushCount,
  output logic [15:0] memWaitCount
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } hz_state_t;

  // Counter reload values: the first stall/flush cycle is spent in RUN,
  // so the counter covers only the remaining cycles.
  localparam logic [2:0] LU_RELOAD = 3'(LU_STALL - 1);
  localparam logic [2:0] FL_RELOAD = 3'(FLUSH_CYCLES - 1);

  hz_state_t  state_r;
  hz_state_t  state_next_s;
  logic [2:0] cnt_r;
  logic [2:0] cnt_next_s;
  logic       lu_hit_s;
  logic       stall_s;
  logic       flush_s;
  logic       mem_s;

  // Load-use detection.
  // True when the EX load writes a register that the ID instruction reads.
  function automatic logic lu_hit_f(
    input logic [3:0] op_id,
    input logic [3:0] r1,
    input logic [3:0] r2,
    input logic       r1_used,
    input logic       r2_used,
    input logic [3:0] op_ex,
    input logic [3:0] rd,
    input logic       wr_en
  );
    logic dep_s;
    dep_s = (r1_used && (r1 == rd)) || (r2_used && (r2 == rd));
    return (op_ex == OP_LW) && wr_en && (op_id != OP_NOP) && dep_s;
  endfunction

  assign lu_hit_s = lu_hit_f(opId, reg1Id, reg2Id, reg1UsedId, reg2UsedId,
                             opEx, regDestEx, wrEnEx);

  // State and remaining-cycle counter; an asynchronous reset aborts any sequence.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_RUN;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state logic and control intent.
  // Priority order: memBusy, then redirect, then load-use.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    stall_s      = 1'b0;
    flush_s      = 1'b0;
    mem_s        = 1'b0;
    if (memBusy) begin
      // EX is frozen too, so pending redirect/load-use re-present later.
      mem_s = 1'b1;
    end else if (redirectEx) begin
      // A redirect wins in every state and abandons any stall in progress.
      flush_s = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_next_s = ST_FLUSH;
        cnt_next_s   = FL_RELOAD;
      end else begin
        state_next_s = ST_RUN;
        cnt_next_s   = 3'd0;
      end
    end else begin
      case (state_r)
        ST_RUN: begin
          if (lu_hit_s) begin
            stall_s = 1'b1;
            if (LU_STALL > 1) begin
              state_next_s = ST_STALL;
              cnt_next_s   = LU_RELOAD;
            end else begin
              state_next_s = ST_RUN;
              cnt_next_s   = 3'd0;
            end
          end else begin
            state_next_s = ST_RUN;
            cnt_next_s   = 3'd0;
          end
        end
        ST_STALL: begin
          stall_s = 1'b1;
          if (cnt_r <= 3'd1) begin
            state_next_s = ST_RUN;
            cnt_next_s   = 3'd0;
          end else begin
            cnt_next_s = cnt_r - 3'd1;
          end
        end
        ST_FLUSH: begin
          // The dependent instruction is being flushed, so load-use is ignored.
          flush_s = 1'b1;
          if (cnt_r <= 3'd1) begin
            state_next_s = ST_RUN;
            cnt_next_s   = 3'd0;
          end else begin
            cnt_next_s = cnt_r - 3'd1;
          end
        end
        default: begin
          state_next_s = ST_RUN;
          cnt_next_s   = 3'd0;
        end
      endcase
    end
  end

  // Drive the outputs. Reset gating keeps every control low while reset_n is low.
  assign stallPc   = stall_s & reset_n;
  assign stallIfId = stall_s & reset_n;
  assign bubbleEx  = stall_s & reset_n;
  assign flushIfId = flush_s & reset_n;
  assign flushIdEx = flush_s & reset_n;
  assign stallAll  = mem_s   & reset_n;
  assign hzState   = state_r;

`ifdef HAZARD_STATS_EN
  logic [15:0] lu_cnt_r;
  logic [15:0] fl_cnt_r;
  logic [15:0] mw_cnt_r;

  // Saturating per-event-group cycle counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lu_cnt_r <= 16'd0;
      fl_cnt_r <= 16'd0;
      mw_cnt_r <= 16'd0;
    end else begin
      if (stall_s && (lu_cnt_r != 16'hFFFF)) lu_cnt_r <= lu_cnt_r + 16'd1;
      if (flush_s && (fl_cnt_r != 16'hFFFF)) fl_cnt_r <= fl_cnt_r + 16'd1;
      if (mem_s   && (mw_cnt_r != 16'hFFFF)) mw_cnt_r <= mw_cnt_r + 16'd1;
    end
  end

  assign luStallCount = lu_cnt_r;
  assign flushCount   = fl_cnt_r;
  assign memWaitCount = mw_cnt_r;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller.
// Two instances share one stimulus stream:
//   - dut_a: LU_STALL=3, FLUSH_CYCLES=2
//   - dut_b: LU_STALL=1, FLUSH_CYCLES=1 (defaults)
// The reference model tracks the remaining stall and flush cycles as integers.
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] opId, reg1Id, reg2Id, opEx, regDestEx;
  logic       reg1UsedId, reg2UsedId, wrEnEx, redirectEx, memBusy;

  logic       a_spc, a_sif, a_bub, a_fif, a_fie, a_all;
  logic [1:0] a_hz;
  logic       b_spc, b_sif, b_bub, b_fif, b_fie, b_all;
  logic [1:0] b_hz;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int rs_a = 0, rf_a = 0, rs_b = 0, rf_b = 0;
  int st_lu = 0, st_fl = 0, st_mw = 0;

`ifdef HAZARD_STATS_EN
  logic [15:0] a_luc, a_flc, a_mwc, b_luc, b_flc, b_mwc;
`endif

  always #5 clk = ~clk;

  hazard_controller #(.LU_STALL(3), .FLUSH_CYCLES(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .opId(opId), .reg1Id(reg1Id), .reg2Id(reg2Id),
    .reg1UsedId(reg1UsedId), .reg2UsedId(reg2UsedId), .opEx(opEx),
    .regDestEx(regDestEx), .wrEnEx(wrEnEx), .redirectEx(redirectEx),
    .memBusy(memBusy), .stallPc(a_spc), .stallIfId(a_sif), .bubbleEx(a_bub),
    .flushIfId(a_fif), .flushIdEx(a_fie), .stallAll(a_all), .hzState(a_hz)
`ifdef HAZARD_STATS_EN
    , .luStallCount(a_luc), .flushCount(a_flc), .memWaitCount(a_mwc)
`endif
  );

  hazard_controller #(.LU_STALL(1), .FLUSH_CYCLES(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .opId(opId), .reg1Id(reg1Id), .reg2Id(reg2Id),
    .reg1UsedId(reg1UsedId), .reg2UsedId(reg2UsedId), .opEx(opEx),
    .regDestEx(regDestEx), .wrEnEx(wrEnEx), .redirectEx(redirectEx),
    .memBusy(memBusy), .stallPc(b_spc), .stallIfId(b_sif), .bubbleEx(b_bub),
    .flushIfId(b_fif), .flushIdEx(b_fie), .stallAll(b_all), .hzState(b_hz)
`ifdef HAZARD_STATS_EN
    , .luStallCount(b_luc), .flushCount(b_flc), .memWaitCount(b_mwc)
`endif
  );

  task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic lu_hit();
    return (opEx == 4'b0100) && wrEnEx && (opId != 4'b0000) &&
           ((reg1UsedId && reg1Id == regDestEx) || (reg2UsedId && reg2Id == regDestEx));
  endfunction

  // Expected {stallPc,stallIfId,bubbleEx,flushIfId,flushIdEx,stallAll,hzState}.
  // rs/rf are the cycles still owed to a stall or flush after this one.
  task automatic model_step(input int lu, input int fc, inout int rs, inout int rf,
                            output logic [7:0] ex);
    logic st, fl, ma;
    logic [1:0] hz;
    st = 1'b0; fl = 1'b0; ma = 1'b0;
    hz = (rs > 0) ? 2'd1 : (rf > 0) ? 2'd2 : 2'd0;
    if (!reset_n) begin
      rs = 0; rf = 0; hz = 2'd0;
    end else if (memBusy) begin
      ma = 1'b1;
    end else if (redirectEx) begin
      fl = 1'b1; rs = 0; rf = fc - 1;
    end else if (rf > 0) begin
      fl = 1'b1; rf = rf - 1;
    end else if (rs > 0) begin
      st = 1'b1; rs = rs - 1;
    end else if (lu_hit()) begin
      st = 1'b1; rs = lu - 1;
    end
    ex = {st, st, st, fl, fl, ma, hz};
  endtask

  // One clock cycle with the inputs already driven: check at negedge, then advance.
  task automatic cycle_t();
    logic [7:0] ea, eb;
    @(negedge clk);
`ifdef HAZARD_STATS_EN
    chk_val("a_lu_count", {16'd0, a_luc}, st_lu);
    chk_val("a_fl_count", {16'd0, a_flc}, st_fl);
    chk_val("a_mw_count", {16'd0, a_mwc}, st_mw);
`endif
    model_step(3, 2, rs_a, rf_a, ea);
    model_step(1, 1, rs_b, rf_b, eb);
    chk_val("dut_a_ctrl", {24'd0, a_spc, a_sif, a_bub, a_fif, a_fie, a_all, a_hz}, {24'd0, ea});
    chk_val("dut_b_ctrl", {24'd0, b_spc, b_sif, b_bub, b_fif, b_fie, b_all, b_hz}, {24'd0, eb});
    if (reset_n) begin
      if (ea[7] && st_lu < 65535) st_lu++;
      if (ea[4] && st_fl < 65535) st_fl++;
      if (ea[2] && st_mw < 65535) st_mw++;
    end else begin
      st_lu = 0; st_fl = 0; st_mw = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    opId = 4'h0; reg1Id = 4'h0; reg2Id = 4'h0; reg1UsedId = 1'b0; reg2UsedId = 1'b0;
    opEx = 4'h0; regDestEx = 4'h0; wrEnEx = 1'b0; redirectEx = 1'b0; memBusy = 1'b0;
  endtask

  task automatic set_lw_hit();
    opEx = 4'b0100; wrEnEx = 1'b1; regDestEx = 4'd5;
    opId = 4'h1; reg1Id = 4'd5; reg1UsedId = 1'b1; reg2Id = 4'd2; reg2UsedId = 1'b0;
  endtask

  // The EX stage moves on to the bubble after the load.
  task automatic ex_bubble();
    opEx = 4'b0000; wrEnEx = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    set_idle();
    cycle_t();
    cycle_t();
    reset_n = 1'b1;
    cycle_t();

    // Load-use on reg1: one cycle for dut_b, three cycles for dut_a.
    set_lw_hit();
    cycle_t();
    ex_bubble();
    repeat (4) cycle_t();

    // A reg2 match does not stall when reg2 is not read.
    set_idle();
    opEx = 4'b0100; wrEnEx = 1'b1; regDestEx = 4'd7;
    opId = 4'h3; reg2Id = 4'd7; reg2UsedId = 1'b0; reg1Id = 4'd1; reg1UsedId = 1'b1;
    repeat (2) cycle_t();

    // Single-cycle redirect.
    set_idle();
    redirectEx = 1'b1;
    cycle_t();
    redirectEx = 1'b0;
    repeat (3) cycle_t();

    // Redirect in the second cycle of a load-use stall.
    set_lw_hit();
    cycle_t();
    ex_bubble();
    redirectEx = 1'b1;
    cycle_t();
    redirectEx = 1'b0;
    repeat (3) cycle_t();

    // Memory wait in the middle of a load-use stall.
    set_lw_hit();
    cycle_t();
    ex_bubble();
    cycle_t();
    memBusy = 1'b1;
    repeat (4) cycle_t();
    memBusy = 1'b0;
    repeat (3) cycle_t();

    // Asynchronous reset in the middle of a flush.
    set_idle();
    redirectEx = 1'b1;
    cycle_t();
    redirectEx = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_val("async_rst_a", {24'd0, a_spc, a_sif, a_bub, a_fif, a_fie, a_all, a_hz}, 32'd0);
    chk_val("async_rst_b", {24'd0, b_spc, b_sif, b_bub, b_fif, b_fie, b_all, b_hz}, 32'd0);
    rs_a = 0; rf_a = 0; rs_b = 0; rf_b = 0;
    st_lu = 0; st_fl = 0; st_mw = 0;
`ifdef HAZARD_STATS_EN
    chk_val("rst_lu_count", {16'd0, a_luc}, 32'd0);
    chk_val("rst_fl_count", {16'd0, a_flc}, 32'd0);
    chk_val("rst_mw_count", {16'd0, a_mwc}, 32'd0);
`endif
    cycle_t();
    reset_n = 1'b1;
    cycle_t();

    // Randomized traffic.
    // Small register range so load-use hits are frequent.
    for (int i = 0; i < 3000; i++) begin
      opId       = 4'($urandom_range(0, 3));
      reg1Id     = 4'($urandom_range(0, 3));
      reg2Id     = 4'($urandom_range(0, 3));
      reg1UsedId = 1'($urandom_range(0, 1));
      reg2UsedId = 1'($urandom_range(0, 1));
      opEx       = ($urandom_range(0, 1) == 0) ? 4'b0100 : 4'($urandom_range(0, 15));
      regDestEx  = 4'($urandom_range(0, 3));
      wrEnEx     = ($urandom_range(0, 3) != 0);
      redirectEx = ($urandom_range(0, 9) == 0);
      memBusy    = ($urandom_range(0, 6) == 0);
      reset_n    = ($urandom_range(0, 199) != 0);
      cycle_t();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline hazard sequencer for the 5-stage core. It sits beside the operand-forwarding unit and covers the hazards forwarding cannot resolve: load-use stalls, flushes on branch/jump redirect, and multi-cycle data-memory waits.
- It drives the PC/IF-ID hold, the ID/EX bubble and the IF-ID/ID-EX flush controls.
- A small FSM with a cycle counter makes sure each stall or flush lasts exactly the configured number of cycles.

Parameters:
- OP_LW, 4'b0100, load-word opcode compared against opEx.
- OP_NOP, 4'b0000, opcode treated as no-write.
- LU_STALL, 1, load-use stall length in cycles (1..7).
- FLUSH_CYCLES, 1, redirect flush length in cycles (1..7).

Ports:
- clk  in  1  single pipeline clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- opId  in  4  opcode of the instruction in ID.
- reg1Id  in  4  source register 1 index in ID.
- reg2Id  in  4  source register 2 index in ID.
- reg1UsedId  in  1  ID instruction reads reg1.
- reg2UsedId  in  1  ID instruction reads reg2.
- opEx  in  4  opcode of the instruction in EX.
- regDestEx  in  4  destination register of the EX instruction.
- wrEnEx  in  1  EX instruction writes the register file.
- redirectEx  in  1  EX resolved a taken branch/jump (PC redirect this cycle).
- memBusy  in  1  data memory not ready; the whole pipe must freeze.
- stallPc  out  1  hold the PC.
- stallIfId  out  1  hold the IF/ID register.
- bubbleEx  out  1  load a NOP into ID/EX.
- flushIfId  out  1  clear IF/ID to a NOP.
- flushIdEx  out  1  clear ID/EX to a NOP.
- stallAll  out  1  freeze every pipeline register (memory wait).
- hzState  out  2  FSM state: 0 RUN, 1 STALL, 2 FLUSH.

Behaviour:
- Reset:
  - While reset_n=0: state=RUN, cnt=0, and every output is 0 regardless of the other inputs.
  - Reset asserted mid-stall or mid-flush aborts it immediately.
- Load-use condition (luHit):
  - opEx==OP_LW && wrEnEx && opId!=OP_NOP, and
  - (reg1UsedId && reg1Id==regDestEx) || (reg2UsedId && reg2Id==regDestEx).
- Event priority, evaluated each cycle:
  - memBusy first, then redirectEx, then luHit.
- memBusy=1, in any state:
  - stallAll=1; all other control outputs 0.
  - state and cnt hold.
  - redirectEx and luHit are ignored that cycle; EX is held, so they re-present after memBusy drops.
- RUN, redirectEx=1:
  - flushIfId=flushIdEx=1 in the same cycle (combinational). stallPc=0, so the redirect target is fetched.
  - If FLUSH_CYCLES>1: next state FLUSH, cnt=FLUSH_CYCLES-1.
- RUN, luHit=1 (no redirect):
  - stallPc=stallIfId=bubbleEx=1 in the same cycle.
  - If LU_STALL>1: next state STALL, cnt=LU_STALL-1.
- STALL:
  - Asserts stallPc, stallIfId, bubbleEx.
  - cnt decrements each cycle; when cnt==1 the next state is RUN.
  - redirectEx in STALL: the stall is abandoned and the RUN redirect actions apply this cycle (flush outputs on, stall outputs off). Next state is FLUSH with cnt=FLUSH_CYCLES-1, or RUN if FLUSH_CYCLES==1.
- FLUSH:
  - Asserts flushIfId and flushIdEx.
  - cnt decrements; when cnt==1 the next state is RUN.
  - A new redirectEx in FLUSH reloads cnt=FLUSH_CYCLES-1, or returns to RUN if FLUSH_CYCLES==1.
  - luHit is ignored in FLUSH, because the dependent instruction is being flushed.
- Latency and counter:
  - Decision-to-output latency is 0 cycles; outputs are combinational from state and inputs.
  - Total stall/flush length is exactly LU_STALL / FLUSH_CYCLES cycles.
  - cnt is 3 bits and never wraps: it stops at 0, and state returns to RUN.
- Output consistency:
  - stallPc==stallIfId always.
  - Flush outputs and stall/bubble outputs are never asserted together.
  - stallAll is exclusive with all other control outputs.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined:
  - Adds outputs luStallCount[15:0], flushCount[15:0] and memWaitCount[15:0].
  - Each counter increments on every cycle its respective output group is asserted: stallPc for load-use, flushIfId for flush, stallAll for memory wait.
  - Counters saturate at 16'hFFFF and are cleared by reset_n.
- When undefined: the ports and counters are absent, with no behavioural change to the controls.

Test Plan:
- Load-use, default LU_STALL=1: opEx=OP_LW, wrEnEx=1, regDestEx=5, reg1Id=5, reg1UsedId=1. Stall outputs =1 for exactly 1 cycle, hzState stays 0; with the EX inputs then advanced to the bubble (opEx=OP_NOP, wrEnEx=0), the stall outputs return to 0.
- LU_STALL=3, same hit: stall outputs =1 for 3 consecutive cycles, hzState=1 for cycles 2-3, then RUN. A hit on reg2 with reg2UsedId=0 produces no stall.
- Redirect, FLUSH_CYCLES=2: redirectEx=1 for one cycle. flushIfId=flushIdEx=1 for 2 cycles, stallPc=0 throughout, hzState=2 in cycle 2.
- Redirect during the second cycle of a 3-cycle load-use stall: stall outputs drop that cycle, flush outputs rise, and the flush lasts FLUSH_CYCLES.
- memBusy=1 for 4 cycles in the middle of a 3-cycle STALL: stallAll=1 with other outputs 0 during the wait; the remaining stall cycles resume afterwards, for 3 stall cycles in total.
- reset_n pulsed low asynchronously mid-FLUSH: all outputs 0 immediately, hzState=0. With HAZARD_STATS_EN defined, the counters read 0 after reset.
